// File: rtl/multiplier_s_pipelined_split_param_if.sv
// Operand/result handshake bundle for multiplier_s_pipelined_split_param.
// Purpose : carries one operand beat (A, B, per-operand sign flags, split
//           select) with in_valid/in_ready, and the product C with
//           out_valid/out_ready.
// Modports: master - the producer/consumer around the multiplier
//           slave  - the multiplier itself
interface multiplier_s_pipelined_split_param_if #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18
);
  logic                       in_valid;
  logic                       in_ready;
  logic [A_WIDTH-1:0]         A;
  logic [B_WIDTH-1:0]         B;
  logic                       A_sign;
  logic                       B_sign;
  logic                       HALF_0;
  logic                       out_valid;
  logic                       out_ready;
  logic [A_WIDTH+B_WIDTH-1:0] C;

  modport master (
    output in_valid, A, B, A_sign, B_sign, HALF_0, out_ready,
    input  in_ready, out_valid, C
  );

  modport slave (
    input  in_valid, A, B, A_sign, B_sign, HALF_0, out_ready,
    output in_ready, out_valid, C
  );
endinterface

// File: rtl/multiplier_s_pipelined_split_param.sv
// Parametrised pipelined Baugh-Wooley multiplier with optional SIMD split.
// Purpose : per beat, either one A_WIDTH x B_WIDTH product (HALF_0=0) or two
//           independent half-width lane products packed into C (HALF_0=1).
//           Each operand is treated as two's complement when its sign flag is
//           set (in split mode the flag applies to both lanes).
// Ports   : clk     - rising-edge clock
//           reset_n - synchronous active-low reset
//           bus     - slave side of the operand/result handshake bundle
// Timing  : the product is formed combinationally from the incoming beat and
//           carried through PIPE_STAGES registers; the last one drives C.
//           The whole pipe advances only when in_ready is high.
module multiplier_s_pipelined_split_param #(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int PIPE_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  multiplier_s_pipelined_split_param_if.slave bus
);

  localparam int W  = A_WIDTH + B_WIDTH;
  localparam int HA = A_WIDTH / 2;
  localparam int HB = B_WIDTH / 2;
  localparam int HW = HA + HB;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Baugh-Wooley product of the low na bits of a by the low nb bits of b,
  // exact modulo 2^(na+nb). A partial product carries negative weight when
  // exactly one of its bits is a sign bit; such a term -x*2^k is rewritten
  // as ~x*2^k - 2^k, so it is inverted and 2^k joins the correction
  // constant that is subtracted at the end.
  function automatic logic [W-1:0] bw_mult(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b,
    input int                 na,
    input int                 nb,
    input logic               sa,
    input logic               sb
  );
    logic [W-1:0] acc;
    logic [W-1:0] corr;
    logic [W-1:0] mask;
    logic         pp;
    logic         a_msb;
    logic         b_msb;
    acc  = '0;
    corr = '0;
    for (int i = 0; i < A_WIDTH; i++) begin
      for (int j = 0; j < B_WIDTH; j++) begin
        if (i < na && j < nb) begin
          pp    = a[i] & b[j];
          a_msb = sa && (i == na - 1);
          b_msb = sb && (j == nb - 1);
          if (a_msb != b_msb) begin
            acc  = acc + ({{(W-1){1'b0}}, ~pp} << (i + j));
            corr = corr + (ONE << (i + j));
          end else begin
            acc  = acc + ({{(W-1){1'b0}}, pp} << (i + j));
          end
        end
      end
    end
    // When na+nb == W the shift yields 0 and the mask becomes all ones.
    mask = (ONE << (na + nb)) - ONE;
    return (acc - corr) & mask;
  endfunction

  logic                   en_s;
  logic [W-1:0]           full_s;
  logic [W-1:0]           lane_lo_s;
  logic [W-1:0]           lane_hi_s;
  logic [W-1:0]           prod_s;
  logic [PIPE_STAGES-1:0] valid_r;
  logic [W-1:0]           prod_r [PIPE_STAGES];

  // A stalled output register blocks the whole pipe; this is the only
  // combinational input-to-output path.
  assign en_s         = ~valid_r[PIPE_STAGES-1] | bus.out_ready;
  assign bus.in_ready = en_s;
  assign bus.out_valid = valid_r[PIPE_STAGES-1];
  assign bus.C         = prod_r[PIPE_STAGES-1];

  // Product of the incoming beat in the mode it carries; the split lanes see
  // only their own operand halves, so no cross-lane term or carry exists.
  always_comb begin
    full_s    = bw_mult(bus.A, bus.B, A_WIDTH, B_WIDTH, bus.A_sign, bus.B_sign);
    lane_lo_s = bw_mult(bus.A, bus.B, HA, HB, bus.A_sign, bus.B_sign);
    lane_hi_s = bw_mult(bus.A >> HA, bus.B >> HB, HA, HB, bus.A_sign, bus.B_sign);
    prod_s    = '0;
    if (bus.HALF_0) begin
      prod_s = {lane_hi_s[HW-1:0], lane_lo_s[HW-1:0]};
    end else begin
      prod_s = full_s;
    end
  end

  // Pipeline registers: clear on reset, shift when enabled, otherwise hold.
  // Bubbles carry a zero product so C never shows a stale value as data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        prod_r[s] <= '0;
      end
    end else if (en_s) begin
      valid_r[0] <= bus.in_valid;
      prod_r[0]  <= bus.in_valid ? prod_s : '0;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        valid_r[s] <= valid_r[s-1];
        prod_r[s]  <= prod_r[s-1];
      end
    end
  end

endmodule

// File: tb/tb_multiplier_s_pipelined_split_param.sv
// Directed self-checking bench: dut_a uses PIPE_STAGES=2, dut_b uses
// PIPE_STAGES=3 (backpressure case). A select bit routes stimulus to one DUT.
module tb_multiplier_s_pipelined_split_param;

  logic clk;
  logic reset_n;
  logic sel;
  logic in_valid_d;
  logic out_ready_d;
  logic [17:0] a_d;
  logic [17:0] b_d;
  logic sa_d;
  logic sb_d;
  logic h_d;

  int n_tests;
  int n_fail;

  logic [17:0] beat_a   [8];
  logic [17:0] beat_b   [8];
  logic        beat_sa  [8];
  logic        beat_sb  [8];
  logic        beat_h   [8];
  logic [35:0] beat_exp [8];

  multiplier_s_pipelined_split_param_if #(.A_WIDTH(18), .B_WIDTH(18)) ifa ();
  multiplier_s_pipelined_split_param_if #(.A_WIDTH(18), .B_WIDTH(18)) ifb ();

  multiplier_s_pipelined_split_param #(.A_WIDTH(18), .B_WIDTH(18), .PIPE_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  multiplier_s_pipelined_split_param #(.A_WIDTH(18), .B_WIDTH(18), .PIPE_STAGES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  assign ifa.in_valid  = in_valid_d & ~sel;
  assign ifb.in_valid  = in_valid_d & sel;
  assign ifa.out_ready = out_ready_d;
  assign ifb.out_ready = out_ready_d;
  assign ifa.A = a_d;   assign ifb.A = a_d;
  assign ifa.B = b_d;   assign ifb.B = b_d;
  assign ifa.A_sign = sa_d;  assign ifb.A_sign = sa_d;
  assign ifa.B_sign = sb_d;  assign ifb.B_sign = sb_d;
  assign ifa.HALF_0 = h_d;   assign ifb.HALF_0 = h_d;

  wire        out_valid_s = sel ? ifb.out_valid : ifa.out_valid;
  wire        in_ready_s  = sel ? ifb.in_ready  : ifa.in_ready;
  wire [35:0] c_s         = sel ? ifb.C         : ifa.C;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int idx, input logic [17:0] a, input logic [17:0] b,
                          input logic sa, input logic sb, input logic h, input logic [35:0] e);
    beat_a[idx] = a;  beat_b[idx] = b;  beat_sa[idx] = sa;
    beat_sb[idx] = sb; beat_h[idx] = h; beat_exp[idx] = e;
  endtask

  task automatic drive(input int idx);
    a_d = beat_a[idx]; b_d = beat_b[idx]; sa_d = beat_sa[idx];
    sb_d = beat_sb[idx]; h_d = beat_h[idx];
  endtask

  // Streams n beats back to back; the first `stall` cycles after the first
  // out_valid are backpressured. exp_last is the cycle of the final transfer.
  task automatic stream(input string tag, input int n, input int stall, input int exp_last);
    int sent;
    int got;
    int stall_left;
    int last_xfer;
    sent = 0; got = 0; stall_left = stall; last_xfer = 0;
    for (int cyc = 1; cyc <= 60 && got < n; cyc++) begin
      in_valid_d = (sent < n);
      if (sent < n) drive(sent);
      out_ready_d = 1'b1;
      if (out_valid_s && stall_left > 0) out_ready_d = 1'b0;
      #1;
      if (!out_ready_d) begin
        stall_left--;
        check($sformatf("%s stall in_ready c%0d", tag, cyc), in_ready_s, 1'b0);
        check($sformatf("%s hold C c%0d", tag, cyc), c_s, beat_exp[got]);
      end
      if (out_valid_s && out_ready_d) begin
        check($sformatf("%s result %0d", tag, got), c_s, beat_exp[got]);
        got++;
        last_xfer = cyc;
      end
      if (in_valid_d && in_ready_s) sent++;
      step();
    end
    in_valid_d = 1'b0;
    check($sformatf("%s delivered", tag), got, n);
    check($sformatf("%s last cycle", tag), last_xfer, exp_last);
  endtask

  initial begin
    int seen;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; sel = 1'b0; in_valid_d = 1'b0; out_ready_d = 1'b1;
    a_d = '0; b_d = '0; sa_d = 1'b0; sb_d = 1'b0; h_d = 1'b0;
    step(); step();
    check("reset a out_valid", ifa.out_valid, 1'b0);
    check("reset a C", ifa.C, 36'h0);
    check("reset a in_ready", ifa.in_ready, 1'b1);
    check("reset b out_valid", ifb.out_valid, 1'b0);
    check("reset b C", ifb.C, 36'h0);
    reset_n = 1'b1;
    step();

    // Test 1: full unsigned, latency of exactly two edges.
    set_beat(0, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 36'hFFFF80001);
    drive(0); in_valid_d = 1'b1;
    step();
    in_valid_d = 1'b0;
    check("t1 out_valid after 1 edge", ifa.out_valid, 1'b0);
    step();
    check("t1 out_valid after 2 edges", ifa.out_valid, 1'b1);
    check("t1 C", ifa.C, 36'hFFFF80001);
    step();
    check("t1 drained", ifa.out_valid, 1'b0);

    // Test 2: mixed signedness and the signed corner case.
    set_beat(0, 18'h3FFFF, 18'h00003, 1'b1, 1'b0, 1'b0, 36'hFFFFFFFFD);
    set_beat(1, 18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 36'h400000000);
    stream("t2", 2, 0, 4);

    // Test 3: split signed, then split unsigned on the same operands.
    set_beat(0, 18'h00FFD, 18'h3FC05, 1'b1, 1'b1, 1'b1, 36'hFFFCBFFF1);
    set_beat(1, 18'h00FFD, 18'h3FC05, 1'b0, 1'b0, 1'b1, 36'h037C809F1);
    stream("t3", 2, 0, 4);

    // Test 4: mode interleave full/split/full, no bubbles.
    set_beat(0, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 36'hFFFF80001);
    set_beat(1, 18'h00FFD, 18'h3FC05, 1'b1, 1'b1, 1'b1, 36'hFFFCBFFF1);
    set_beat(2, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 36'hFFFF80001);
    stream("t4", 3, 0, 5);

    // Test 5: three-stage pipe, five beats, four cycles of backpressure.
    sel = 1'b1;
    set_beat(0, 18'h00002, 18'h00003, 1'b0, 1'b0, 1'b0, 36'h000000006);
    set_beat(1, 18'h3FFFF, 18'h00003, 1'b1, 1'b0, 1'b0, 36'hFFFFFFFFD);
    set_beat(2, 18'h00FFD, 18'h3FC05, 1'b1, 1'b1, 1'b1, 36'hFFFCBFFF1);
    set_beat(3, 18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 36'h400000000);
    set_beat(4, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 36'hFFFF80001);
    stream("t5", 5, 4, 12);
    sel = 1'b0;

    // Test 6: reset while two beats are in flight and output is stalled.
    out_ready_d = 1'b0;
    drive(0); in_valid_d = 1'b1;
    step();
    drive(1);
    step();
    in_valid_d = 1'b0;
    reset_n = 1'b0;
    step();
    check("t6 out_valid", ifa.out_valid, 1'b0);
    check("t6 C", ifa.C, 36'h0);
    check("t6 in_ready", ifa.in_ready, 1'b1);
    reset_n = 1'b1; out_ready_d = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ifa.out_valid) seen++;
    end
    check("t6 no stale result", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
